// File: rtl/mem_pkg.sv
// Shared types for the two-port memory arbiter.
// Port identifiers and the pending-read record live here.
package mem_pkg;

    localparam int MEM_WORDS = 4096;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_id_e;

    typedef struct packed {
        logic     valid;
        port_id_e port;
        logic     oor;
    } rd_pend_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single-port program/data memory between the CPU and a DMA
// port: CPU priority, starvation-bounded DMA, out-of-range rejection.
module mem_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MEM_WORDS = mem_pkg::MEM_WORDS,
    parameter int MAX_WAIT  = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          rq0_req,
    input  logic          rq0_we,
    input  logic [AW-1:0] rq0_addr,
    input  logic [DW-1:0] rq0_wdata,
    output logic          rq0_gnt,
    output logic          rq0_rvalid,
    output logic [DW-1:0] rq0_rdata,
    output logic          rq0_err,

    input  logic          rq1_req,
    input  logic          rq1_we,
    input  logic [AW-1:0] rq1_addr,
    input  logic [DW-1:0] rq1_wdata,
    output logic          rq1_gnt,
    output logic          rq1_rvalid,
    output logic [DW-1:0] rq1_rdata,
    output logic          rq1_err,

    output logic [AW-1:0] mem_Address,
    output logic          mem_Rden,
    output logic          mem_Wren,
    output logic [DW-1:0] mem_Dout,
    input  logic [DW-1:0] mem_Din,

    output logic [2:0]    wait_cnt
);

    import mem_pkg::*;

    localparam logic [2:0]  MAX_W = 3'(MAX_WAIT);
    localparam int unsigned LIM   = MEM_WORDS;
    localparam logic [AW:0] LIMIT = LIM[AW:0];

    logic [2:0] wait_cnt_q, wait_cnt_d;
    rd_pend_t   rd_pend_q, rd_pend_d;

    logic          gnt0, gnt1, win_any;
    port_id_e      win_port;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_oor;

    // DMA is forced through once it has been starved MAX_WAIT cycles
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (rq0_req && rq1_req) begin
                if (wait_cnt_q == MAX_W) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else begin
                gnt0 = rq0_req;
                gnt1 = rq1_req;
            end
        end
    end

    assign win_any  = gnt0 | gnt1;
    assign win_port = gnt1 ? PORT_DMA : PORT_CPU;

    always_comb begin
        sel_we    = rq0_we;
        sel_addr  = rq0_addr;
        sel_wdata = rq0_wdata;
        if (gnt1) begin
            sel_we    = rq1_we;
            sel_addr  = rq1_addr;
            sel_wdata = rq1_wdata;
        end
    end

    assign sel_oor = ({1'b0, sel_addr} >= LIMIT);

    always_comb begin
        mem_Address = '0;
        mem_Dout    = '0;
        mem_Rden    = 1'b0;
        mem_Wren    = 1'b0;
        if (win_any) begin
            mem_Address = sel_addr;
            mem_Dout    = sel_wdata;
            mem_Wren    = sel_we & ~sel_oor;
            mem_Rden    = ~sel_we & ~sel_oor;
        end
    end

    assign rq0_gnt = gnt0;
    assign rq1_gnt = gnt1;
    assign rq0_err = gnt0 & sel_oor;
    assign rq1_err = gnt1 & sel_oor;

    always_comb begin
        wait_cnt_d = '0;
        if (rq1_req && !gnt1) begin
            if (wait_cnt_q == MAX_W) begin
                wait_cnt_d = MAX_W;
            end else begin
                wait_cnt_d = wait_cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        rd_pend_d       = '0;
        rd_pend_d.valid = win_any & ~sel_we;
        rd_pend_d.port  = win_port;
        rd_pend_d.oor   = sel_oor;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            rd_pend_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    // Out-of-range reads still return a beat, but with zero data
    always_comb begin
        rq0_rvalid = 1'b0;
        rq1_rvalid = 1'b0;
        rq0_rdata  = '0;
        rq1_rdata  = '0;
        if (rd_pend_q.valid) begin
            if (rd_pend_q.port == PORT_CPU) begin
                rq0_rvalid = 1'b1;
                rq0_rdata  = rd_pend_q.oor ? '0 : mem_Din;
            end else begin
                rq1_rvalid = 1'b1;
                rq1_rdata  = rd_pend_q.oor ? '0 : mem_Din;
            end
        end
    end

    assign wait_cnt = wait_cnt_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single-port 4K-word program/data memory between the CPU (port 0) and a loader/DMA requester (port 1). It sits between the CPU's memory interface and the `memory` block. It grants one access per cycle using fixed priority to the CPU, with a starvation counter that guarantees port 1 progress. It also rejects out-of-range addresses without touching memory.

## Interface
Parameters:
- `AW`, 16: address width.
- `DW`, 16: data width.
- `MEM_WORDS`, 4096: number of implemented memory words; legal addresses are 0..MEM_WORDS-1.
- `MAX_WAIT`, 4: consecutive cycles port 1 may be denied while requesting before it is forced to win.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `rq0_req`, `rq1_req` in 1 each: access request.
- `rq0_we`, `rq1_we` in 1 each: 1 = write, 0 = read.
- `rq0_addr`, `rq1_addr` in AW each: word address.
- `rq0_wdata`, `rq1_wdata` in DW each: write data.
- `rq0_gnt`, `rq1_gnt` out 1 each: access accepted this cycle.
- `rq0_rvalid`, `rq1_rvalid` out 1 each: read data valid.
- `rq0_rdata`, `rq1_rdata` out DW each: read data.
- `rq0_err`, `rq1_err` out 1 each: out-of-range access flag.
- `mem_Address` out AW: memory address.
- `mem_Rden` out 1: memory read enable.
- `mem_Wren` out 1: memory write enable.
- `mem_Dout` out DW: write data to memory.
- `mem_Din` in DW: read data from memory, valid one cycle after `mem_Rden`.
- `wait_cnt` out 3: current port-1 starvation count, for debug.

## Operation
- Requester handshake:
  - Assert `req` and hold `we`/`addr`/`wdata` stable until `gnt` is high at a rising edge.
  - `gnt` is combinational from the current `req` values and registered state.
  - At most one `gnt` is high per cycle.
  - One access completes per `gnt` cycle.
  - Keeping `req` high after `gnt` requests a new, back-to-back access.
- Arbitration:
  - Only one port requesting → that port wins.
  - Both requesting → port 0 wins, unless `wait_cnt == MAX_WAIT`, in which case port 1 wins.
- `wait_cnt` register:
  - Increments, saturating at MAX_WAIT, on each cycle where `rq1_req` is high and port 1 is not granted.
  - Clears when port 1 is granted or when `rq1_req` is low.
- Memory strobes in the grant cycle:
  - `mem_Address`/`mem_Dout` = winner's `addr`/`wdata`.
  - `mem_Wren` = winner's `we`; `mem_Rden` = ~winner's `we`.
  - Strobes are gated off when the address is out of range or there is no winner.
  - With no grant, `mem_Address` and `mem_Dout` are 0.
- Out-of-range (`addr >= MEM_WORDS`):
  - `gnt` still pulses; no memory strobe is issued.
  - The port's `err` pulses in the grant cycle.
  - A read additionally produces `rvalid` next cycle with `rdata` = 0.
- Read return:
  - Pending-read register captures `{valid, port, oor}` at the grant edge.
  - In the next cycle the captured port sees `rvalid` = 1 and `rdata` = `mem_Din` (0 if oor).
  - The other port's `rdata` is 0.
- Writes produce no `rvalid`.
- Asynchronous `reset` mid-operation:
  - Clears `wait_cnt` and the pending-read register immediately.
  - The outstanding `rvalid` is dropped.
  - No `gnt`, strobe or `err` is issued while `reset` is high.

## Timing
- Reset values: all `gnt`, `rvalid`, `err` = 0; all `rdata` = 0; `mem_Rden` = `mem_Wren` = 0; `mem_Address` = `mem_Dout` = 0; `wait_cnt` = 0.
- Latency:
  - Grant: 0 cycles from `req` when the port wins.
  - Write: committed at the grant edge.
  - Read data: 1 cycle after grant.
- Throughput: one access per cycle, back-to-back reads pipelined.
- A read grant to port 0 followed by a grant to port 1 returns data to port 0 then port 1 on consecutive cycles, with no bubble.
- Port 1 worst-case wait under continuous port 0 traffic is MAX_WAIT cycles, so it is granted on cycle MAX_WAIT+1.

## Structure
- Shared package `mem_pkg`:
  - `MEM_WORDS` constant.
  - `port_id_e` enum (`PORT_CPU` = 0, `PORT_DMA` = 1).
  - `rd_pend_t` packed struct {valid, port, oor}.
- Single flat module; no sub-module warranted. Arbitration decode and strobe mux are combinational; `wait_cnt` and `rd_pend_t` are the only state.

## Test plan
- Port 0 writes 16'hBEEF to address 10, then reads address 10 → `rq0_gnt` pulses on both; `mem_Wren` then `mem_Rden`; `rq0_rvalid` = 1 with `rq0_rdata` = 16'hBEEF one cycle after the read grant.
- Both ports request reads continuously with MAX_WAIT = 4 → grant pattern 0,0,0,0,1 repeating; `wait_cnt` sequence 1,2,3,4,0.
- Port 1 reads address 16'h1000 → `rq1_gnt` and `rq1_err` pulse; `mem_Rden` stays 0; next cycle `rq1_rvalid` = 1 with `rq1_rdata` = 0.
- Port 0 reads address 5 (preloaded 16'h0007) in cycle t, port 1 reads address 6 (preloaded 16'h0009) in cycle t+1 → `rq0_rvalid`/16'h0007 at t+1, `rq1_rvalid`/16'h0009 at t+2.
- Assert `reset` asynchronously in the cycle after a port 0 read grant → `rq0_rvalid` never asserts; all outputs at reset values while `reset` is high; normal grants resume on the first edge after release.
- No requests for 10 cycles → all strobes, `gnt`, `rvalid` and `err` remain 0; `wait_cnt` stays 0.
